cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: TAG_W, default 5, physical register tag width.
REQ-002 Parameter: DATA_W, default 32, result data width.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset_i  input  1  reset, asynchronous, active-low.
REQ-005 Ports, for each of x = alu, mul, lsu:
- x_done_i  input  1  FU result valid.
- x_tag_i  input  TAG_W  destination tag.
- x_data_i  input  DATA_W  result.
- x_stall_o  output  1  arbiter cannot accept; FU holds its result.
REQ-006 Port: flush_i  input  1  synchronous pipeline flush.
REQ-007 Port: cdb_en_o  output  1  CDB broadcast valid.
REQ-008 Port: cdb_tag_o  output  TAG_W  broadcast tag.
REQ-009 Port: cdb_data_o  output  DATA_W  broadcast data.
REQ-010 Port: cdb_src_o  output  2  winning source (0 ALU, 1 MUL, 2 LSU).

Function
REQ-011 Each source SHALL own a one-entry holding register (hold_v, tag, data).
REQ-012 Accept: at a rising edge, x_done_i=1 and x_stall_o=0 loads x_tag_i/x_data_i into the holding register and sets hold_v.
REQ-013 When x_done_i=1 and x_stall_o=1, the arbiter ignores the input; the FU holds it until accepted.
REQ-014 x_stall_o SHALL be combinational: flush_i | (hold_v_x & ~grant_x).
REQ-015 Arbitration SHALL be combinational among sources with hold_v=1, at most one grant per cycle.
REQ-016 Arbitration order SHALL be round-robin, starting at rr_ptr (2-bit, legal values 0..2).
REQ-017 At the edge ending a granted cycle:
- the winner's tag/data/src load into the cdb_*_o registers and cdb_en_o <= 1;
- the winner's hold_v clears, unless a new result is accepted on the same edge;
- rr_ptr <= winner+1, wrapping 2 -> 0.
REQ-018 In a cycle with no grant, cdb_en_o <= 0, rr_ptr is unchanged, and cdb_tag_o/cdb_data_o/cdb_src_o hold their last values.
REQ-019 Latency: a result accepted at edge k with no competitor SHALL appear on the CDB after edge k+1 and stay valid for exactly one cycle.
REQ-020 Throughput: a single source completing every cycle with no competitors SHALL see cdb_en_o=1 every cycle and x_stall_o never asserted.
REQ-021 Fairness: a held entry SHALL be granted within 3 cycles of its hold_v setting.
REQ-022 Each accepted result SHALL be broadcast exactly once, with no duplication or loss, unless flushed.
REQ-023 Flush: at an edge with flush_i=1:
- all hold_v clear;
- cdb_en_o <= 0;
- x_done_i is ignored (x_stall_o=1 that cycle);
- rr_ptr is unchanged.
REQ-024 Flush has priority over accept and grant.
REQ-025 A result already on the CDB during the flush cycle SHALL still be considered broadcast.

Reset
REQ-026 Asserting reset_i (low) SHALL, without a clock edge:
- clear all hold_v;
- set cdb_en_o=0, cdb_tag_o=0, cdb_data_o=0, cdb_src_o=0;
- set rr_ptr=0.
REQ-027 While reset_i=0, all x_stall_o SHALL read 0 and all x_done_i SHALL be ignored.
REQ-028 Deassertion SHALL be synchronized by the integrator. The first edge after release SHALL behave as a normal cycle with ALU highest priority.

Verification
REQ-029 ALU done, tag 5, data 0xDEADBEEF, at edge 1 -> cdb_en_o=1 after edge 2 with tag 5, data 0xDEADBEEF, src 0; cdb_en_o=0 after edge 3.
REQ-030 ALU/MUL/LSU done on the same edge (tags 1/2/3), rr_ptr=0:
- CDB tags 1, 2, 3 on three consecutive cycles;
- mul_stall_o high 1 cycle, lsu_stall_o high 2 cycles.
REQ-031 rr_ptr=2 with ALU and LSU held -> LSU broadcast first, then ALU; rr_ptr ends at 1.
REQ-032 ALU done every cycle for 8 cycles, tags 0..7 -> 8 consecutive CDB cycles carrying tags 0..7 in order; alu_stall_o stays 0.
REQ-033 MUL and LSU held, flush_i pulsed for 1 cycle:
- neither tag broadcast;
- all stall_o high during the flush cycle;
- an ALU done on the next cycle is broadcast normally.
REQ-034 reset_i low mid-broadcast, between clock edges -> cdb_en_o, hold_v and rr_ptr cleared immediately; no pre-reset tag appears after release.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus arbiter: one holding slot per FU, round-robin grant, registered broadcast
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              alu_done_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_stall_o,
    input  logic              mul_done_i,
    input  logic [TAG_W-1:0]  mul_tag_i,
    input  logic [DATA_W-1:0] mul_data_i,
    output logic              mul_stall_o,
    input  logic              lsu_done_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_stall_o,
    input  logic              flush_i,
    output logic              cdb_en_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [1:0]        cdb_src_o
);

    logic [2:0]        done;
    logic [TAG_W-1:0]  in_tag  [3];
    logic [DATA_W-1:0] in_data [3];

    logic [2:0]        hold_v_q;
    logic [TAG_W-1:0]  hold_tag_q  [3];
    logic [DATA_W-1:0] hold_data_q [3];
    logic [1:0]        rr_q, rr_d;
    logic              cdb_en_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [1:0]        cdb_src_q;

    logic [2:0] grant, stall, accept;
    logic [1:0] win, start, idx;
    logic [2:0] sum;
    logic       found, grant_v;

    assign done       = {lsu_done_i, mul_done_i, alu_done_i};
    assign in_tag[0]  = alu_tag_i;
    assign in_tag[1]  = mul_tag_i;
    assign in_tag[2]  = lsu_tag_i;
    assign in_data[0] = alu_data_i;
    assign in_data[1] = mul_data_i;
    assign in_data[2] = lsu_data_i;

    // First held source at or after rr_q, scanning 0..2 cyclically
    always_comb begin
        start = (rr_q == 2'd3) ? 2'd0 : rr_q;
        found = 1'b0;
        win   = 2'd0;
        sum   = 3'd0;
        idx   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, start} + 3'(i);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && hold_v_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        grant_v = found & ~flush_i;
        grant   = 3'b000;
        grant[win] = grant_v;
        rr_d    = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end

    // A granted slot frees this cycle, so its FU may refill on the same edge
    assign stall  = {3{reset_i}} & ({3{flush_i}} | (hold_v_q & ~grant));
    assign accept = done & ~stall;

    assign alu_stall_o = stall[0];
    assign mul_stall_o = stall[1];
    assign lsu_stall_o = stall[2];

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            hold_v_q   <= 3'b000;
            rr_q       <= 2'd0;
            cdb_en_q   <= 1'b0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
            cdb_src_q  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
        end else if (flush_i) begin
            hold_v_q <= 3'b000;
            cdb_en_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (accept[i]) begin
                    hold_v_q[i]    <= 1'b1;
                    hold_tag_q[i]  <= in_tag[i];
                    hold_data_q[i] <= in_data[i];
                end else if (grant[i]) begin
                    hold_v_q[i] <= 1'b0;
                end
            end
            cdb_en_q <= grant_v;
            if (grant_v) begin
                cdb_tag_q  <= hold_tag_q[win];
                cdb_data_q <= hold_data_q[win];
                cdb_src_q  <= win;
                rr_q       <= rr_d;
            end
        end
    end

    assign cdb_en_o   = cdb_en_q;
    assign cdb_tag_o  = cdb_tag_q;
    assign cdb_data_o = cdb_data_q;
    assign cdb_src_o  = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              alu_done_i, mul_done_i, lsu_done_i;
    logic [TAG_W-1:0]  alu_tag_i, mul_tag_i, lsu_tag_i;
    logic [DATA_W-1:0] alu_data_i, mul_data_i, lsu_data_i;
    logic              alu_stall_o, mul_stall_o, lsu_stall_o;
    logic              flush_i;
    logic              cdb_en_o;
    logic [TAG_W-1:0]  cdb_tag_o;
    logic [DATA_W-1:0] cdb_data_o;
    logic [1:0]        cdb_src_o;

    int errors = 0;
    int checks = 0;
    logic [38:0] sb [$];

    always #5 clk_i = ~clk_i;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .alu_done_i(alu_done_i), .alu_tag_i(alu_tag_i), .alu_data_i(alu_data_i), .alu_stall_o(alu_stall_o),
        .mul_done_i(mul_done_i), .mul_tag_i(mul_tag_i), .mul_data_i(mul_data_i), .mul_stall_o(mul_stall_o),
        .lsu_done_i(lsu_done_i), .lsu_tag_i(lsu_tag_i), .lsu_data_i(lsu_data_i), .lsu_stall_o(lsu_stall_o),
        .flush_i(flush_i), .cdb_en_o(cdb_en_o), .cdb_tag_o(cdb_tag_o),
        .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        sb.push_back({src, tag, data});
    endtask

    // Advance one edge; any broadcast must match the oldest outstanding result
    task automatic tick();
        logic [38:0] e;
        @(posedge clk_i);
        #1;
        if (cdb_en_o) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {cdb_src_o, cdb_tag_o, cdb_data_o}, 39'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_broadcast", {cdb_src_o, cdb_tag_o, cdb_data_o}, e);
            end
        end
    endtask

    task automatic set_alu(input logic d, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        alu_done_i = d; alu_tag_i = t; alu_data_i = v;
    endtask
    task automatic set_mul(input logic d, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        mul_done_i = d; mul_tag_i = t; mul_data_i = v;
    endtask
    task automatic set_lsu(input logic d, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        lsu_done_i = d; lsu_tag_i = t; lsu_data_i = v;
    endtask

    initial begin
        reset_i = 1'b0;
        flush_i = 1'b0;
        set_alu(1'b1, 5'd1, 32'h1);
        set_mul(1'b1, 5'd2, 32'h2);
        set_lsu(1'b1, 5'd3, 32'h3);
        #1;
        chk("rst_en", cdb_en_o, 0);
        chk("rst_tag", cdb_tag_o, 0);
        chk("rst_data", cdb_data_o, 0);
        chk("rst_src", cdb_src_o, 0);
        chk("rst_stalls", {alu_stall_o, mul_stall_o, lsu_stall_o}, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_en_held", cdb_en_o, 0);
        reset_i = 1'b1;

        // All three on one edge, rr at 0
        push(2'd0, 5'd1, 32'h1);
        push(2'd1, 5'd2, 32'h2);
        push(2'd2, 5'd3, 32'h3);
        tick();
        set_alu(1'b0, 5'd0, 32'h0); set_mul(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
        #1;
        chk("c3_en0", cdb_en_o, 0);
        chk("c3_stall1", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b011);
        tick();
        chk("c3_en1", cdb_en_o, 1);
        chk("c3_stall2", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b001);
        tick();
        chk("c3_en2", cdb_en_o, 1);
        chk("c3_stall3", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b000);
        tick();
        chk("c3_en3", cdb_en_o, 1);
        tick();
        chk("c3_en_off", cdb_en_o, 0);

        // Single ALU result latency
        set_alu(1'b1, 5'd5, 32'hDEADBEEF);
        push(2'd0, 5'd5, 32'hDEADBEEF);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        chk("lat_edge1", cdb_en_o, 0);
        tick();
        chk("lat_edge2", cdb_en_o, 1);
        tick();
        chk("lat_edge3", cdb_en_o, 0);
        chk("lat_tag_hold", cdb_tag_o, 5);
        chk("lat_data_hold", cdb_data_o, 32'hDEADBEEF);

        // MUL alone moves rr to 2; then ALU+LSU -> LSU first
        set_mul(1'b1, 5'd7, 32'h77);
        push(2'd1, 5'd7, 32'h77);
        tick();
        set_mul(1'b0, 5'd0, 32'h0);
        tick();
        set_alu(1'b1, 5'd10, 32'hA0);
        set_lsu(1'b1, 5'd12, 32'hC0);
        push(2'd2, 5'd12, 32'hC0);
        push(2'd0, 5'd10, 32'hA0);
        tick();
        set_alu(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
        tick();
        chk("rr2_src_first", cdb_src_o, 2);
        tick();
        chk("rr2_src_second", cdb_src_o, 0);
        tick();
        chk("rr2_idle", cdb_en_o, 0);
        // rr should now be 1: MUL beats ALU
        set_alu(1'b1, 5'd14, 32'hE0);
        set_mul(1'b1, 5'd15, 32'hF0);
        push(2'd1, 5'd15, 32'hF0);
        push(2'd0, 5'd14, 32'hE0);
        tick();
        set_alu(1'b0, 5'd0, 32'h0); set_mul(1'b0, 5'd0, 32'h0);
        tick();
        chk("rr1_src_first", cdb_src_o, 1);
        tick();
        tick();
        chk("rr1_idle", cdb_en_o, 0);

        // Back-to-back ALU stream
        for (int i = 0; i < 8; i++) begin
            set_alu(1'b1, 5'(i), 32'h100 + 32'(i));
            push(2'd0, 5'(i), 32'h100 + 32'(i));
            #1;
            chk("stream_stall", alu_stall_o, 0);
            tick();
            chk("stream_en", cdb_en_o, (i > 0) ? 1'b1 : 1'b0);
        end
        set_alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("stream_last", cdb_en_o, 1);
        chk("stream_last_tag", cdb_tag_o, 7);
        tick();
        chk("stream_end", cdb_en_o, 0);

        // Flush drops held MUL and LSU results
        set_mul(1'b1, 5'd13, 32'hD0);
        set_lsu(1'b1, 5'd14, 32'hD1);
        tick();
        set_mul(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
        flush_i = 1'b1;
        #1;
        chk("flush_stalls", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b111);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_en", cdb_en_o, 0);
        chk("flush_cleared", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b000);
        set_alu(1'b1, 5'd9, 32'h99);
        push(2'd0, 5'd9, 32'h99);
        tick();
        set_alu(1'b0, 5'd0, 32'h0);
        chk("post_flush_en0", cdb_en_o, 0);
        tick();
        chk("post_flush_en1", cdb_en_o, 1);
        tick();
        chk("post_flush_idle", cdb_en_o, 0);

        // Reset during a broadcast (rr at 1 -> MUL first)
        set_alu(1'b1, 5'd17, 32'h1111);
        set_mul(1'b1, 5'd18, 32'h1212);
        push(2'd1, 5'd18, 32'h1212);
        push(2'd0, 5'd17, 32'h1111);
        tick();
        set_alu(1'b0, 5'd0, 32'h0); set_mul(1'b0, 5'd0, 32'h0);
        tick();
        chk("pre_rst_en", cdb_en_o, 1);
        #2;
        reset_i = 1'b0;
        set_alu(1'b1, 5'd20, 32'h20); set_mul(1'b1, 5'd21, 32'h21); set_lsu(1'b1, 5'd22, 32'h22);
        #1;
        chk("midrst_en", cdb_en_o, 0);
        chk("midrst_tag", cdb_tag_o, 0);
        chk("midrst_src", cdb_src_o, 0);
        chk("midrst_stalls", {alu_stall_o, mul_stall_o, lsu_stall_o}, 3'b000);
        sb.delete();
        @(posedge clk_i);
        @(negedge clk_i);
        set_alu(1'b0, 5'd0, 32'h0); set_mul(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
        reset_i = 1'b1;
        tick();
        chk("rel_idle1", cdb_en_o, 0);
        tick();
        chk("rel_idle2", cdb_en_o, 0);

        // After reset ALU has top priority again
        set_alu(1'b1, 5'd26, 32'h2A);
        set_mul(1'b1, 5'd27, 32'h2B);
        set_lsu(1'b1, 5'd28, 32'h2C);
        push(2'd0, 5'd26, 32'h2A);
        push(2'd1, 5'd27, 32'h2B);
        push(2'd2, 5'd28, 32'h2C);
        tick();
        set_alu(1'b0, 5'd0, 32'h0); set_mul(1'b0, 5'd0, 32'h0); set_lsu(1'b0, 5'd0, 32'h0);
        tick();
        chk("rel_src_first", cdb_src_o, 0);
        tick();
        tick();
        tick();
        chk("rel_idle3", cdb_en_o, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
